// File: rtl/psram_arbiter_if.sv
// ----------------------------------------------------------------------------
// psram_arbiter_if
// Bundles every signal that runs between the requester fabric, the arbiter
// and the quad-SPI PSRAM master.
//
// Requester side (per port, packed; port i lives at [i*W +: W]):
//   req_valid/req_we/req_addr/req_len   burst command from each port
//   req_ready                           one-cycle accept pulse
//   wdata / wdata_ack                   write data and word-consumed pulse
//   rdata / rdata_valid                 shared read data, per-port valid
//   done / err                          burst finished, err = timeout abort
// Master side:
//   m_addr, m_data_in, m_wr_req, m_rd_req    arbiter -> master
//   m_data_out, m_wr_valid, m_rd_valid       master  -> arbiter
//
// Modports: slave  = the arbiter's view
//           master = the environment's view (requesters + PSRAM master)
// ----------------------------------------------------------------------------
interface psram_arbiter_if #(
    parameter int NREQ = 2,
    parameter int ASZ  = 22,
    parameter int DSZ  = 16,
    parameter int LSZ  = 8
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_we;
    logic [NREQ*ASZ-1:0] req_addr;
    logic [NREQ*LSZ-1:0] req_len;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DSZ-1:0] wdata;
    logic [NREQ-1:0]     wdata_ack;
    logic [DSZ-1:0]      rdata;
    logic [NREQ-1:0]     rdata_valid;
    logic [NREQ-1:0]     done;
    logic                err;
    logic [ASZ-1:0]      m_addr;
    logic [DSZ-1:0]      m_data_in;
    logic [DSZ-1:0]      m_data_out;
    logic                m_wr_req;
    logic                m_rd_req;
    logic                m_wr_valid;
    logic                m_rd_valid;

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wdata,
        input  m_data_out, m_wr_valid, m_rd_valid,
        output req_ready, wdata_ack, rdata, rdata_valid, done, err,
        output m_addr, m_data_in, m_wr_req, m_rd_req
    );

    modport master (
        output req_valid, req_we, req_addr, req_len, wdata,
        output m_data_out, m_wr_valid, m_rd_valid,
        input  req_ready, wdata_ack, rdata, rdata_valid, done, err,
        input  m_addr, m_data_in, m_wr_req, m_rd_req
    );
endinterface

// File: rtl/psram_arbiter.sv
// ----------------------------------------------------------------------------
// psram_arbiter
// Round-robin arbiter sharing one quad-SPI PSRAM master between NREQ ports.
// A granted burst command (direction, address, length) is latched, the
// master's level request is held for exactly len+1 words, and then a
// minimum deselect gap is enforced before the next grant. A watchdog aborts
// a burst that sees no master strobe for TMO cycles (done with err=1).
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    psram_arbiter_if.slave - requester and master signals
// ----------------------------------------------------------------------------
module psram_arbiter #(
    parameter int NREQ = 2,
    parameter int ASZ  = 22,
    parameter int DSZ  = 16,
    parameter int LSZ  = 8,
    parameter int GAP  = 4,
    parameter int TMO  = 255
) (
    input  logic           clk,
    input  logic           reset,
    psram_arbiter_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam int PW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    state_t         state_q, state_d;
    logic           we_q, we_d;
    logic [ASZ-1:0] addr_q, addr_d;
    logic [LSZ-1:0] len_q, len_d;
    logic [GW-1:0]  gnt_q, gnt_d;
    logic [GW-1:0]  last_q, last_d;
    logic [LSZ:0]   cnt_q, cnt_d;
    logic [TW-1:0]  wdog_q, wdog_d;
    logic [PW-1:0]  gap_q, gap_d;
    logic [DSZ-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [NREQ-1:0] done_q, done_d;
    logic           err_q, err_d;

    // Per-port views of the packed command/data buses.
    logic [ASZ-1:0] addr_arr  [NREQ];
    logic [LSZ-1:0] len_arr   [NREQ];
    logic [DSZ-1:0] wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*ASZ +: ASZ];
            assign len_arr[gi]   = bus.req_len[gi*LSZ +: LSZ];
            assign wdata_arr[gi] = bus.wdata[gi*DSZ +: DSZ];
        end
    endgenerate

    // Round-robin search: rotate the request vector so that the port after
    // last_grant sits at bit 0, then take the lowest set bit.
    logic [GW:0]     rot_amt;
    logic [NREQ-1:0] rot;
    logic            found;
    logic [GW-1:0]   pick;

    always_comb begin
        rot_amt = {1'b0, last_q} + 1'b1;
        rot     = NREQ'({bus.req_valid, bus.req_valid} >> rot_amt);
        found   = 1'b0;
        pick    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pick  = GW'((int'(last_q) + 1 + k) % NREQ);
            end
        end
    end

    logic            in_burst;
    logic            wr_hit;
    logic            rd_hit;
    logic [NREQ-1:0] gnt_oh;
    logic [NREQ-1:0] pick_oh;

    assign in_burst = (state_q == S_BURST);
    // Only strobes matching the latched direction during a burst count.
    assign wr_hit   = in_burst &  we_q & bus.m_wr_valid;
    assign rd_hit   = in_burst & ~we_q & bus.m_rd_valid;
    assign gnt_oh   = NREQ'(1) << gnt_q;
    assign pick_oh  = NREQ'(1) << pick;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        len_d    = len_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        wdog_d   = wdog_q;
        gap_d    = gap_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;
        done_d   = '0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    we_d    = bus.req_we[pick];
                    addr_d  = addr_arr[pick];
                    len_d   = len_arr[pick];
                    gnt_d   = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    wdog_d  = '0;
                    state_d = S_BURST;
                end
            end

            S_BURST: begin
                if (wr_hit || rd_hit) begin
                    if (rd_hit) begin
                        rdata_d  = bus.m_data_out;
                        rvalid_d = gnt_oh;
                    end
                    wdog_d = '0;
                    cnt_d  = cnt_q + 1'b1;
                    // A final strobe wins over a watchdog expiry in the same cycle.
                    if (cnt_d == ({1'b0, len_q} + 1'b1)) begin
                        done_d  = gnt_oh;
                        gap_d   = PW'(GAP - 1);
                        state_d = S_GAP;
                    end
                end else if (wdog_q == TW'(TMO - 1)) begin
                    done_d  = gnt_oh;
                    err_d   = 1'b1;
                    gap_d   = PW'(GAP - 1);
                    state_d = S_GAP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            S_GAP: begin
                // GAP-1 cycles here plus the IDLE grant cycle give exactly
                // GAP cycles of deasserted master request between bursts.
                if (gap_q <= PW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            gnt_q    <= '0;
            last_q   <= GW'(NREQ - 1);
            cnt_q    <= '0;
            wdog_q   <= '0;
            gap_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
            gap_q    <= gap_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Acceptance is combinational in IDLE; held off while reset is asserted
    // so every output reads zero during reset.
    assign bus.req_ready   = (state_q == S_IDLE && found && !reset) ? pick_oh : '0;
    assign bus.wdata_ack   = wr_hit ? gnt_oh : '0;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.m_addr      = addr_q;
    assign bus.m_data_in   = in_burst ? wdata_arr[gnt_q] : '0;
    assign bus.m_wr_req    = in_burst &  we_q;
    assign bus.m_rd_req    = in_burst & ~we_q;
endmodule

// File: tb/tb_psram_arbiter.sv
module tb_psram_arbiter;
    localparam int NREQ = 2;
    localparam int ASZ  = 22;
    localparam int DSZ  = 16;
    localparam int LSZ  = 8;
    localparam int GAP  = 4;
    localparam int TMO  = 255;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    psram_arbiter_if #(.NREQ(NREQ), .ASZ(ASZ), .DSZ(DSZ), .LSZ(LSZ)) bus ();

    psram_arbiter #(
        .NREQ(NREQ), .ASZ(ASZ), .DSZ(DSZ), .LSZ(LSZ), .GAP(GAP), .TMO(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic set_port(input int p, input logic we, input logic [ASZ-1:0] a,
                            input logic [LSZ-1:0] l);
        bus.req_we[p]               = we;
        bus.req_addr[p*ASZ +: ASZ]  = a;
        bus.req_len[p*LSZ +: LSZ]   = l;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_len = '0;
        bus.wdata = '0; bus.m_data_out = '0; bus.m_wr_valid = 1'b0; bus.m_rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({bus.m_wr_req, bus.m_rd_req, bus.done, bus.err, bus.rdata_valid,
             bus.wdata_ack, bus.req_ready} !== '0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0", {bus.m_wr_req,
                bus.m_rd_req, bus.done, bus.err, bus.rdata_valid, bus.wdata_ack, bus.req_ready});
        end
        checks++;
        if (bus.m_addr !== '0 || bus.rdata !== '0 || bus.m_data_in !== '0) begin
            errors++; $display("FAIL reset_data: got addr=%h rdata=%h din=%h expected 0",
                bus.m_addr, bus.rdata, bus.m_data_in);
        end
        reset = 1'b0;
        $display("reset: outputs cleared");
    endtask

    task automatic test_write();
        logic [15:0] words [3] = '{16'hA5A5, 16'h5A5A, 16'hFFFF};
        int acks = 0;
        @(negedge clk);
        set_port(0, 1'b1, 22'h001234, 8'd2);
        bus.wdata[0 +: DSZ] = words[0];
        bus.req_valid = 2'b01;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01 || bus.m_wr_req !== 1'b0) begin
            errors++; $display("FAIL wr_grant: got ready=%b wr_req=%b expected 01/0",
                bus.req_ready, bus.m_wr_req);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.m_wr_req !== 1'b1 || bus.m_rd_req !== 1'b0 || bus.m_addr !== 22'h001234) begin
            errors++; $display("FAIL wr_start: got wr=%b rd=%b addr=%h expected 1/0/001234",
                bus.m_wr_req, bus.m_rd_req, bus.m_addr);
        end
        for (int w = 0; w < 3; w++) begin
            bus.wdata[0 +: DSZ] = words[w];
            repeat (7) @(negedge clk);
            #1;
            checks++;
            if (bus.m_wr_req !== 1'b1) begin
                errors++; $display("FAIL wr_hold%0d: got wr_req=%b expected 1", w, bus.m_wr_req);
            end
            bus.m_wr_valid = 1'b1;
            #1;
            checks++;
            if (bus.wdata_ack !== 2'b01 || bus.m_data_in !== words[w]) begin
                errors++; $display("FAIL wr_word%0d: got ack=%b din=%h expected 01/%h",
                    w, bus.wdata_ack, bus.m_data_in, words[w]);
            end
            if (bus.wdata_ack[0] === 1'b1) acks++;
            @(negedge clk);
            bus.m_wr_valid = 1'b0;
        end
        #1;
        checks++;
        if (bus.done !== 2'b01 || bus.err !== 1'b0 || bus.m_wr_req !== 1'b0 || acks != 3) begin
            errors++; $display("FAIL wr_done: got done=%b err=%b wr_req=%b acks=%0d expected 01/0/0/3",
                bus.done, bus.err, bus.m_wr_req, acks);
        end
        $display("write port0 addr=001234 len=2 acks=%0d", acks);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_read();
        @(negedge clk);
        set_port(1, 1'b0, 22'h3FFFFF, 8'd0);
        bus.req_valid = 2'b10;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL rd_grant: got ready=%b expected 10", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.m_rd_req !== 1'b1 || bus.m_wr_req !== 1'b0 || bus.m_addr !== 22'h3FFFFF) begin
            errors++; $display("FAIL rd_start: got rd=%b wr=%b addr=%h expected 1/0/3fffff",
                bus.m_rd_req, bus.m_wr_req, bus.m_addr);
        end
        @(negedge clk);
        #1;
        bus.m_rd_valid = 1'b1;
        bus.m_wr_valid = 1'b1;
        bus.m_data_out = 16'hBEEF;
        #1;
        checks++;
        if (bus.wdata_ack !== 2'b00 || bus.rdata_valid !== 2'b00) begin
            errors++; $display("FAIL rd_filter: got ack=%b rvalid=%b expected 00/00",
                bus.wdata_ack, bus.rdata_valid);
        end
        @(negedge clk);
        bus.m_rd_valid = 1'b0;
        bus.m_wr_valid = 1'b0;
        bus.m_data_out = '0;
        #1;
        checks++;
        if (bus.rdata_valid !== 2'b10 || bus.rdata !== 16'hBEEF) begin
            errors++; $display("FAIL rd_data: got rvalid=%b rdata=%h expected 10/beef",
                bus.rdata_valid, bus.rdata);
        end
        checks++;
        if (bus.done !== 2'b10 || bus.err !== 1'b0 || bus.m_rd_req !== 1'b0 || bus.m_wr_req !== 1'b0) begin
            errors++; $display("FAIL rd_done: got done=%b err=%b rd=%b wr=%b expected 10/0/0/0",
                bus.done, bus.err, bus.m_rd_req, bus.m_wr_req);
        end
        $display("read port1 addr=3fffff len=0 rdata=%h", bus.rdata);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        int  ngrant = 0;
        int  nburst = 0;
        int  low    = 0;
        bit  prev   = 1'b0;
        bit  drop   = 1'b0;
        @(negedge clk);
        set_port(0, 1'b1, 22'h000100, 8'd0);
        set_port(1, 1'b1, 22'h000200, 8'd0);
        bus.req_valid = 2'b11;
        for (int c = 0; c < 200 && nburst < 4; c++) begin
            #1;
            if (bus.req_ready !== 2'b00) begin
                checks++;
                if (ngrant >= 4 || bus.req_ready !== exp_order[ngrant]) begin
                    errors++; $display("FAIL b2b_grant%0d: got ready=%b expected %b", ngrant,
                        bus.req_ready, (ngrant < 4) ? exp_order[ngrant] : 2'b00);
                end else begin
                    $display("b2b grant %0d ready=%b", ngrant, bus.req_ready);
                end
                ngrant++;
                if (ngrant == 4) drop = 1'b1;
            end
            if (bus.m_wr_req === 1'b1 && !prev) begin
                nburst++;
                if (nburst > 1) begin
                    checks++;
                    if (low != GAP) begin
                        errors++; $display("FAIL b2b_gap%0d: got %0d low cycles expected %0d",
                            nburst, low, GAP);
                    end
                end
                bus.m_wr_valid = 1'b1;
            end
            if (bus.m_wr_req === 1'b1) low = 0; else low++;
            prev = (bus.m_wr_req === 1'b1);
            @(negedge clk);
            bus.m_wr_valid = 1'b0;
            if (drop) bus.req_valid = '0;
        end
        checks++;
        if (ngrant != 4 || nburst != 4) begin
            errors++; $display("FAIL b2b_count: got grants=%0d bursts=%0d expected 4/4",
                ngrant, nburst);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_long_read();
        int sent = 0;
        int rv   = 0;
        bit dn   = 1'b0;
        @(negedge clk);
        set_port(0, 1'b0, 22'h000040, 8'd255);
        bus.req_valid = 2'b01;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL long_grant: got ready=%b expected 01", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        for (int c = 0; c < 600 && !dn; c++) begin
            #1;
            if (bus.rdata_valid !== 2'b00) begin
                checks++;
                if (bus.rdata_valid !== 2'b01 || bus.rdata !== 16'(rv)) begin
                    errors++; $display("FAIL long_word%0d: got rvalid=%b rdata=%h expected 01/%h",
                        rv, bus.rdata_valid, bus.rdata, 16'(rv));
                end
                rv++;
            end
            if (bus.done !== 2'b00) begin
                dn = 1'b1;
                checks++;
                if (bus.done !== 2'b01 || bus.err !== 1'b0 || rv != 256) begin
                    errors++; $display("FAIL long_done: got done=%b err=%b words=%0d expected 01/0/256",
                        bus.done, bus.err, rv);
                end
            end
            if (bus.m_rd_req === 1'b1 && sent < 300) begin
                bus.m_rd_valid = 1'b1;
                bus.m_data_out = 16'(sent);
                sent++;
            end else begin
                bus.m_rd_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.m_rd_valid = 1'b0;
        checks++;
        if (!dn || sent != 256) begin
            errors++; $display("FAIL long_end: got done_seen=%0d strobes=%0d expected 1/256", dn, sent);
        end
        $display("long read port0 len=255 words=%0d", rv);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_midburst();
        @(negedge clk);
        set_port(1, 1'b1, 22'h2AAAAA, 8'd5);
        bus.wdata[DSZ +: DSZ] = 16'h1357;
        bus.req_valid = 2'b10;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL mid_grant: got ready=%b expected 10", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            #1 bus.m_wr_valid = 1'b1;
            @(negedge clk);
            bus.m_wr_valid = 1'b0;
        end
        #1;
        checks++;
        if (bus.m_wr_req !== 1'b1) begin
            errors++; $display("FAIL mid_active: got wr_req=%b expected 1", bus.m_wr_req);
        end
        set_port(0, 1'b1, 22'h000777, 8'd0);
        bus.req_valid  = 2'b11;
        bus.m_wr_valid = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.m_wr_req, bus.m_rd_req, bus.wdata_ack, bus.req_ready, bus.done,
             bus.err, bus.rdata_valid} !== '0 || bus.m_addr !== '0 || bus.m_data_in !== '0) begin
            errors++; $display("FAIL mid_reset: got wr=%b ack=%b ready=%b addr=%h din=%h expected all 0",
                bus.m_wr_req, bus.wdata_ack, bus.req_ready, bus.m_addr, bus.m_data_in);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.m_wr_valid = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL mid_first: got ready=%b expected 01", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.m_wr_req !== 1'b1 || bus.m_addr !== 22'h000777) begin
            errors++; $display("FAIL mid_regrant: got wr=%b addr=%h expected 1/000777",
                bus.m_wr_req, bus.m_addr);
        end
        bus.m_wr_valid = 1'b1;
        @(negedge clk);
        bus.m_wr_valid = 1'b0;
        #1;
        checks++;
        if (bus.done !== 2'b01 || bus.err !== 1'b0) begin
            errors++; $display("FAIL mid_done: got done=%b err=%b expected 01/0", bus.done, bus.err);
        end
        $display("reset mid-burst: port0 granted first after release");
        repeat (8) @(negedge clk);
    endtask

    task automatic test_timeout();
        int hi  = 0;
        int bad = 0;
        bit dn  = 1'b0;
        @(negedge clk);
        set_port(1, 1'b0, 22'h155555, 8'd3);
        bus.req_valid = 2'b10;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL tmo_grant: got ready=%b expected 10", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        for (int c = 0; c < 400 && !dn; c++) begin
            #1;
            if (bus.m_rd_req === 1'b1) hi++;
            if (bus.done !== 2'b00) begin
                dn = 1'b1;
                checks++;
                if (bus.done !== 2'b10 || bus.err !== 1'b1 || hi != TMO || bus.m_rd_req !== 1'b0) begin
                    errors++; $display("FAIL tmo_abort: got done=%b err=%b high=%0d rd=%b expected 10/1/%0d/0",
                        bus.done, bus.err, hi, bus.m_rd_req, TMO);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (!dn) begin
            errors++; $display("FAIL tmo_wait: got no done within bound expected done");
        end
        // Late strobes through GAP and into IDLE must have no effect.
        bus.m_rd_valid = 1'b1;
        bus.m_wr_valid = 1'b1;
        bus.m_data_out = 16'hDEAD;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (bus.rdata_valid !== 2'b00 || bus.wdata_ack !== 2'b00 || bus.done !== 2'b00 ||
                bus.rdata !== 16'h0000 || bus.m_rd_req !== 1'b0) bad++;
        end
        bus.m_rd_valid = 1'b0;
        bus.m_wr_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL tmo_late: got %0d disturbed cycles rdata=%h expected 0/0000",
                bad, bus.rdata);
        end
        $display("timeout port1 abort after %0d cycles err=1", hi);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_long_read();
        test_reset_midburst();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
